// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing source with latency-matched HS/VS.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
//
// Ports:
//   CLK         in   pixel clock
//   RST_N       in   asynchronous reset, active low
//   h_count     out  pixel column, 0..H_TOTAL-1
//   v_count     out  line, 0..V_TOTAL-1
//   active      out  visible-area flag, aligned with the counters
//   VGA_HS      out  horizontal sync, active low, delayed SYNC_DELAY clocks
//   VGA_VS      out  vertical sync, active low, delayed SYNC_DELAY clocks
//   frame_start out  1-clock pulse while counters are (0,0)
//   frame_end   out  1-clock pulse while counters are (0,V_DISPLAY)
//   frame_cnt   out  frames completed since reset (0 without VGA_FRAME_CNT_EN)
module vga_sync_gen #(
   parameter int H_DISPLAY  = 640,
   parameter int H_FRONT    = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BACK     = 48,
   parameter int V_DISPLAY  = 480,
   parameter int V_FRONT    = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BACK     = 33,
   parameter int SYNC_DELAY = 2
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [9:0]  h_count,
   output logic [9:0]  v_count,
   output logic        active,
   output logic        VGA_HS,
   output logic        VGA_VS,
   output logic        frame_start,
   output logic        frame_end,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_next;
   logic [9:0] v_next;
   logic       hs_raw;
   logic       vs_raw;

   always_comb begin
      h_wrap = (h_count == H_LAST);
      v_wrap = (v_count == V_LAST);
      h_next = h_count + 10'd1;
      v_next = v_count;
      if (h_wrap) begin
         h_next = 10'd0;
         v_next = v_wrap ? 10'd0 : v_count + 10'd1;
      end
   end

   // Strobes look at the next-state counters so that the registered
   // pulse lines up with the cycle the counters hold that position.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         h_count     <= 10'd0;
         v_count     <= 10'd0;
         frame_start <= 1'b0;
         frame_end   <= 1'b0;
      end else begin
         h_count     <= h_next;
         v_count     <= v_next;
         frame_start <= (h_next == 10'd0) && (v_next == 10'd0);
         frame_end   <= (h_next == 10'd0) && (v_next == V_VIS);
      end
   end

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frame_q <= 16'd0;
      end else if (h_wrap && v_wrap) begin
         frame_q <= frame_q + 16'd1;
      end
   end

   assign frame_cnt = frame_q;
`else
   assign frame_cnt = 16'd0;
`endif

   assign active = (h_count < H_VIS) && (v_count < V_VIS);
   assign hs_raw = !((h_count >= HS_START) && (h_count < HS_END));
   assign vs_raw = !((v_count >= VS_START) && (v_count < VS_END));

   generate
      if (SYNC_DELAY == 0) begin : g_nodly
         assign VGA_HS = hs_raw;
         assign VGA_VS = vs_raw;
      end else begin : g_dly
         // Stages reset to 1 so no sync pulse leaks out after reset.
         logic [SYNC_DELAY-1:0] hs_sr;
         logic [SYNC_DELAY-1:0] vs_sr;
         logic [SYNC_DELAY:0]   hs_cat;
         logic [SYNC_DELAY:0]   vs_cat;

         assign hs_cat = {hs_sr, hs_raw};
         assign vs_cat = {vs_sr, vs_raw};

         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               hs_sr <= '1;
               vs_sr <= '1;
            end else begin
               hs_sr <= hs_cat[SYNC_DELAY-1:0];
               vs_sr <= vs_cat[SYNC_DELAY-1:0];
            end
         end

         assign VGA_HS = hs_sr[SYNC_DELAY-1];
         assign VGA_VS = vs_sr[SYNC_DELAY-1];
      end
   endgenerate

endmodule
